// File: rtl/fpu_wb_merge.sv
// fpu_wb_merge: per-channel result FIFOs retired round-robin onto NWP GPR write ports.
// Define WB_BYPASS_EN to let an empty channel's incoming result go straight to a write port.
module fpu_wb_merge #(
  parameter int NCH   = 8,
  parameter int NWP   = 2,
  parameter int DEPTH = 4,
  parameter int SLACK = 2,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    in_valid,
  input  logic [NCH*AW-1:0] in_rt,
  input  logic [NCH*DW-1:0] in_data,
  output logic [NCH-1:0]    hold,
  output logic [NCH-1:0]    overflow,
  output logic [NWP-1:0]    wp_en,
  output logic [NWP*AW-1:0] wp_addr,
  output logic [NWP*DW-1:0] wp_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = (NCH > 1) ? $clog2(NCH) : 1;
`ifdef WB_BYPASS_EN
  localparam int NP = 2;
`else
  localparam int NP = 1;
`endif
  logic [AW-1:0]  r_mrt [NCH][DEPTH];
  logic [DW-1:0]  r_md  [NCH][DEPTH];
  logic [PW-1:0]  r_rd  [NCH];
  logic [PW-1:0]  r_wr  [NCH];
  logic [CW-1:0]  r_cnt [NCH];
  logic [CW-1:0]  w_nxt [NCH];
  logic [RW-1:0]  r_rr, w_rr;
  logic [NCH-1:0] w_pop, w_byp, w_acc, w_drop;
  logic [NWP-1:0] w_pen;
  logic [AW-1:0]  w_paddr [NWP];
  logic [DW-1:0]  w_pdata [NWP];
  // Pass 0 scans FIFO heads; pass 1 (bypass builds only) scans empty channels' live inputs.
  always_comb begin : arb
    int n, c;
    logic hit, elig;
    logic [AW-1:0] rt;
    w_pop = '0;
    w_byp = '0;
    w_pen = '0;
    w_rr  = r_rr;
    n     = 0;
    c     = 0;
    hit   = 1'b0;
    elig  = 1'b0;
    rt    = '0;
    for (int j = 0; j < NWP; j++) begin
      w_paddr[j] = '0;
      w_pdata[j] = '0;
    end
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < NCH; k++) begin
        c    = (int'(r_rr) + k) % NCH;
        elig = (p == 0) ? (r_cnt[c] != '0) : (r_cnt[c] == '0 && in_valid[c]);
        rt   = (p == 0) ? r_mrt[c][r_rd[c]] : in_rt[c*AW +: AW];
        hit  = 1'b0;
        for (int j = 0; j < NWP; j++) hit = hit | (w_pen[j] && w_paddr[j] == rt);
        if (elig && !hit && n < NWP) begin
          w_pen[n]   = 1'b1;
          w_paddr[n] = rt;
          w_pdata[n] = (p == 0) ? r_md[c][r_rd[c]] : in_data[c*DW +: DW];
          w_pop[c]   = (p == 0);
          w_byp[c]   = (p != 0);
          w_rr       = RW'((c + 1) % NCH);
          n++;
        end
      end
  end
  // A full FIFO only takes a push when it also pops this cycle.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_acc[i]  = in_valid[i] && !w_byp[i] && (r_cnt[i] != CW'(DEPTH) || w_pop[i]);
      w_drop[i] = in_valid[i] && !w_byp[i] && !w_acc[i];
      w_nxt[i]  = r_cnt[i] + CW'(w_acc[i]) - CW'(w_pop[i]);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr     <= '0;
      hold     <= '0;
      overflow <= '0;
      wp_en    <= '0;
      wp_addr  <= '0;
      wp_data  <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_rd[i]  <= '0;
        r_wr[i]  <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      r_rr     <= w_rr;
      wp_en    <= w_pen;
      overflow <= overflow | w_drop;
      for (int j = 0; j < NWP; j++)
        if (w_pen[j]) begin
          wp_addr[j*AW +: AW] <= w_paddr[j];
          wp_data[j*DW +: DW] <= w_pdata[j];
        end
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i] <= w_nxt[i];
        hold[i]  <= w_nxt[i] >= CW'(DEPTH - SLACK);
        r_rd[i]  <= r_rd[i] + PW'(w_pop[i]);
        r_wr[i]  <= r_wr[i] + PW'(w_acc[i]);
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++)
      if (w_acc[i]) begin
        r_mrt[i][r_wr[i]] <= in_rt[i*AW +: AW];
        r_md[i][r_wr[i]]  <= in_data[i*DW +: DW];
      end
  end
endmodule
